// File: rtl/csr_file_pkg.sv
// csr_file_pkg: op codes, CSR addresses, mstatus/interrupt bit positions and the RMW helper for csr_file
package csr_file_pkg;

    typedef enum logic [1:0] {
        CSR_NOP = 2'b00,
        CSR_RW  = 2'b01,
        CSR_RS  = 2'b10,
        CSR_RC  = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_DEBUG     = 12'h309;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // Interrupt cause codes double as the mie/mip bit positions.
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    function automatic logic [31:0] csr_wdata(input csr_op_e op, input logic [31:0] old,
                                              input logic [31:0] operand);
        return (op == CSR_RS) ? (old | operand) :
               (op == CSR_RC) ? (old & ~operand) : operand;
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// csr_counter64: 64-bit free-running counter whose halves can be overwritten, a write taking precedence over the increment
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] cnt_o
);
    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = wr_lo_i ? {cnt_q[63:32], wdata_i} :
                wr_hi_i ? {wdata_i, cnt_q[31:0]} :
                inc_i   ? cnt_q + 64'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with RMW access, trap/mret state, 64-bit counters and interrupt gating
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1,
    parameter bit          COUNTERS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_wr_en,
    input  logic [2:0]  csr_op,
    input  logic [4:0]  csr_uimm,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_data_in,
    output logic [31:0] csr_data_out,
    output logic        csr_illegal,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    output logic [31:0] trap_vector,
    output logic [31:0] epc_out,
    output logic        irq_pending
);
    csr_op_e     op;
    logic [31:0] in_data, old_data, wdata, mip, mstatus_rd, mtvec_base;
    logic [63:0] mcycle, minstret, mcycle_rd, minstret_rd;
    logic        implemented, read_only, is_counter, wr_attempt, illegal, do_write;
    logic        wr_mstatus, wr_mie, wr_mtvec, wr_debug, wr_mscratch;
    logic        wr_mepc, wr_mcause, wr_mtval;
    logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, debug_q, debug_d;
    logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0] rdata_q, rdata_d;
    logic        illegal_q, illegal_d;

    assign op          = csr_op_e'(csr_op[1:0]);
    assign in_data     = csr_op[2] ? {27'b0, csr_uimm} : csr_data_in;
    assign mcycle_rd   = COUNTERS_EN ? mcycle : 64'd0;
    assign minstret_rd = COUNTERS_EN ? minstret : 64'd0;

    always_comb begin
        mip = '0;
        mip[IRQ_MEI] = irq_ext;
        mip[IRQ_MTI] = irq_timer;
        mip[IRQ_MSI] = irq_sw;
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
    end

    always_comb begin
        old_data    = '0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   old_data = mstatus_rd;
            CSR_MISA:      old_data = MISA_VALUE;
            CSR_MIE:       old_data = mie_q;
            CSR_MTVEC:     old_data = mtvec_q;
            CSR_DEBUG:     old_data = debug_q;
            CSR_MSCRATCH:  old_data = mscratch_q;
            CSR_MEPC:      old_data = mepc_q;
            CSR_MCAUSE:    old_data = mcause_q;
            CSR_MTVAL:     old_data = mtval_q;
            CSR_MIP:       old_data = mip;
            CSR_MCYCLE:    old_data = mcycle_rd[31:0];
            CSR_MINSTRET:  old_data = minstret_rd[31:0];
            CSR_MCYCLEH:   old_data = mcycle_rd[63:32];
            CSR_MINSTRETH: old_data = minstret_rd[63:32];
            CSR_MHARTID:   old_data = HART_ID;
            default:       implemented = 1'b0;
        endcase
    end

    assign is_counter = (csr_addr == CSR_MCYCLE) || (csr_addr == CSR_MINSTRET) ||
                        (csr_addr == CSR_MCYCLEH) || (csr_addr == CSR_MINSTRETH);
    assign read_only  = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA) ||
                        (csr_addr == CSR_MIP) || (!COUNTERS_EN && is_counter);

    // Set/clear with a zero operand is a pure read and must not trip the read-only check.
    assign wr_attempt = csr_wr_en && (op != CSR_NOP) && ((op == CSR_RW) || (in_data != 32'd0));
    assign illegal    = csr_wr_en && (!implemented || (wr_attempt && read_only));
    assign do_write   = wr_attempt && !illegal;
    assign wdata      = csr_wdata(op, old_data, in_data);

    assign wr_mstatus  = do_write && (csr_addr == CSR_MSTATUS);
    assign wr_mie      = do_write && (csr_addr == CSR_MIE);
    assign wr_mtvec    = do_write && (csr_addr == CSR_MTVEC);
    assign wr_debug    = do_write && (csr_addr == CSR_DEBUG);
    assign wr_mscratch = do_write && (csr_addr == CSR_MSCRATCH);
    assign wr_mepc     = do_write && (csr_addr == CSR_MEPC);
    assign wr_mcause   = do_write && (csr_addr == CSR_MCAUSE);
    assign wr_mtval    = do_write && (csr_addr == CSR_MTVAL);

    // Trap beats mret beats a CSR write on the registers they share.
    always_comb begin
        mstatus_mie_d  = trap_valid ? 1'b0 :
                         mret       ? mstatus_mpie_q :
                         wr_mstatus ? wdata[MSTATUS_MIE_BIT] : mstatus_mie_q;
        mstatus_mpie_d = trap_valid ? mstatus_mie_q :
                         mret       ? 1'b1 :
                         wr_mstatus ? wdata[MSTATUS_MPIE_BIT] : mstatus_mpie_q;
        mepc_d         = trap_valid ? {trap_pc[31:2], 2'b00} :
                         wr_mepc    ? {wdata[31:2], 2'b00} : mepc_q;
        mcause_d       = trap_valid ? trap_cause : wr_mcause ? wdata : mcause_q;
        mtval_d        = trap_valid ? trap_tval : wr_mtval ? wdata : mtval_q;
        mie_d          = wr_mie ? (wdata & MIE_MASK) : mie_q;
        mtvec_d        = wr_mtvec ? {wdata[31:2], (VECTORED_EN && !wdata[1]) ? wdata[1:0] : 2'b00} :
                                    mtvec_q;
        debug_d        = wr_debug ? wdata : debug_q;
        mscratch_d     = wr_mscratch ? wdata : mscratch_q;
        rdata_d        = !csr_wr_en ? rdata_q : illegal ? 32'd0 : old_data;
        illegal_d      = illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            debug_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            rdata_q        <= '0;
            illegal_q      <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            debug_q        <= debug_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            rdata_q        <= rdata_d;
            illegal_q      <= illegal_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (COUNTERS_EN),
        .wr_lo_i (do_write && (csr_addr == CSR_MCYCLE)),
        .wr_hi_i (do_write && (csr_addr == CSR_MCYCLEH)),
        .wdata_i (wdata),
        .cnt_o   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (COUNTERS_EN && instr_retire),
        .wr_lo_i (do_write && (csr_addr == CSR_MINSTRET)),
        .wr_hi_i (do_write && (csr_addr == CSR_MINSTRETH)),
        .wdata_i (wdata),
        .cnt_o   (minstret)
    );

    assign mtvec_base   = {mtvec_q[31:2], 2'b00};
    assign trap_vector  = (VECTORED_EN && mtvec_q[0] && trap_cause[31]) ?
                          mtvec_base + {25'b0, trap_cause[4:0], 2'b00} : mtvec_base;
    assign epc_out      = mepc_q;
    assign irq_pending  = mstatus_mie_q & |(mie_q & mip);
    assign csr_data_out = rdata_q;
    assign csr_illegal  = illegal_q;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed self-checking bench for csr_file
module tb_csr_file;
    localparam logic [2:0] RD  = 3'b000;
    localparam logic [2:0] RW  = 3'b001;
    localparam logic [2:0] RS  = 3'b010;
    localparam logic [2:0] RC  = 3'b011;
    localparam logic [2:0] RSI = 3'b110;
    localparam logic [31:0] HART = 32'h0000_0007;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_wr_en = 1'b0;
    logic [2:0]  csr_op = '0;
    logic [4:0]  csr_uimm = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_data_in = '0;
    logic [31:0] csr_data_out;
    logic        csr_illegal;
    logic        instr_retire = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_tval = '0;
    logic        mret = 1'b0;
    logic        irq_ext = 1'b0;
    logic        irq_timer = 1'b0;
    logic        irq_sw = 1'b0;
    logic [31:0] trap_vector;
    logic [31:0] epc_out;
    logic        irq_pending;
    int          n_checks = 0;
    int          n_fail = 0;

    csr_file #(.HART_ID(HART)) dut (
        .clk(clk), .rst_n(rst_n), .csr_wr_en(csr_wr_en), .csr_op(csr_op), .csr_uimm(csr_uimm),
        .csr_addr(csr_addr), .csr_data_in(csr_data_in), .csr_data_out(csr_data_out),
        .csr_illegal(csr_illegal), .instr_retire(instr_retire), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw), .trap_vector(trap_vector),
        .epc_out(epc_out), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    task automatic csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] d);
        csr_wr_en = 1'b1; csr_op = op; csr_addr = addr; csr_data_in = d; csr_uimm = d[4:0];
        @(posedge clk); #1;
        csr_wr_en = 1'b0; csr_op = RD;
    endtask

    task automatic test_reset;
        n_checks++; if (csr_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want %h", csr_data_out, 32'h0); end
        n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", csr_illegal); end
        n_checks++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want %h", epc_out, 32'h0); end
        n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_pending); end
        n_checks++; if (trap_vector !== 32'h0) begin n_fail++; $display("FAIL reset_tvec: got %h want %h", trap_vector, 32'h0); end
        csr(RD, 12'h300, 32'h0);
        n_checks++; if (csr_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_mstatus: got %h want %h", csr_data_out, 32'h0); end
        csr(RD, 12'h301, 32'h0);
        n_checks++; if (csr_data_out !== 32'h4000_0100) begin n_fail++; $display("FAIL misa: got %h want %h", csr_data_out, 32'h4000_0100); end
    endtask

    task automatic test_rmw;
        csr(RW, 12'h340, 32'hDEAD_BEEF);
        n_checks++; if (csr_data_out !== 32'h0) begin n_fail++; $display("FAIL rw_old: got %h want %h", csr_data_out, 32'h0); end
        csr(RSI, 12'h340, 32'h5);
        n_checks++; if (csr_data_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rs_old: got %h want %h", csr_data_out, 32'hDEAD_BEEF); end
        csr(RC, 12'h340, 32'hFFFF_0000);
        n_checks++; if (csr_data_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rc_old: got %h want %h", csr_data_out, 32'hDEAD_BEEF); end
        csr(RD, 12'h340, 32'h0);
        n_checks++; if (csr_data_out !== 32'h0000_BEEF) begin n_fail++; $display("FAIL rc_result: got %h want %h", csr_data_out, 32'h0000_BEEF); end
        csr(RS, 12'h340, 32'h1234_0000);
        csr(RD, 12'h340, 32'h0);
        n_checks++; if (csr_data_out !== 32'h1234_BEEF) begin n_fail++; $display("FAIL rs_result: got %h want %h", csr_data_out, 32'h1234_BEEF); end
        @(posedge clk); #1;
        n_checks++; if (csr_data_out !== 32'h1234_BEEF) begin n_fail++; $display("FAIL hold: got %h want %h", csr_data_out, 32'h1234_BEEF); end
    endtask

    task automatic test_illegal;
        csr(RW, 12'hF14, 32'h1234);
        n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_hartid_flag: got %b want 1", csr_illegal); end
        n_checks++; if (csr_data_out !== 32'h0) begin n_fail++; $display("FAIL ill_hartid_data: got %h want %h", csr_data_out, 32'h0); end
        @(posedge clk); #1;
        n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_pulse: got %b want 0", csr_illegal); end
        csr(RD, 12'h7FF, 32'h0);
        n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_unimpl: got %b want 1", csr_illegal); end
        csr(RSI, 12'hF14, 32'h0);
        n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL hartid_read_flag: got %b want 0", csr_illegal); end
        n_checks++; if (csr_data_out !== HART) begin n_fail++; $display("FAIL hartid_read: got %h want %h", csr_data_out, HART); end
        csr(RW, 12'h301, 32'h0);
        n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_misa: got %b want 1", csr_illegal); end
        csr(RSI, 12'h344, 32'h1);
        n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_mip: got %b want 1", csr_illegal); end
        csr(RD, 12'h301, 32'h0);
        n_checks++; if (csr_data_out !== 32'h4000_0100) begin n_fail++; $display("FAIL misa_kept: got %h want %h", csr_data_out, 32'h4000_0100); end
        csr(RD, 12'h340, 32'h0);
        n_checks++; if (csr_data_out !== 32'h1234_BEEF) begin n_fail++; $display("FAIL ill_no_change: got %h want %h", csr_data_out, 32'h1234_BEEF); end
    endtask

    task automatic test_counters;
        instr_retire = 1'b1;
        repeat (4) @(posedge clk);
        #1 instr_retire = 1'b0;
        csr(RD, 12'hB02, 32'h0);
        n_checks++; if (csr_data_out !== 32'd4) begin n_fail++; $display("FAIL minstret: got %h want %h", csr_data_out, 32'd4); end
        csr(RD, 12'hB82, 32'h0);
        n_checks++; if (csr_data_out !== 32'd0) begin n_fail++; $display("FAIL minstreth: got %h want %h", csr_data_out, 32'd0); end
        csr(RW, 12'hB00, 32'hFFFF_FFFE);
        csr(RW, 12'hB80, 32'h0);
        csr(RD, 12'hB00, 32'h0);
        n_checks++; if (csr_data_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mcycle_lo: got %h want %h", csr_data_out, 32'hFFFF_FFFE); end
        csr(RD, 12'hB80, 32'h0);
        n_checks++; if (csr_data_out !== 32'h0) begin n_fail++; $display("FAIL mcycleh_before: got %h want %h", csr_data_out, 32'h0); end
        csr(RD, 12'hB80, 32'h0);
        n_checks++; if (csr_data_out !== 32'h1) begin n_fail++; $display("FAIL mcycleh_carry: got %h want %h", csr_data_out, 32'h1); end
        csr(RD, 12'hB00, 32'h0);
        n_checks++; if (csr_data_out !== 32'h1) begin n_fail++; $display("FAIL mcycle_wrap: got %h want %h", csr_data_out, 32'h1); end
    endtask

    task automatic test_trap;
        csr(RW, 12'h300, 32'h8);
        csr(RW, 12'h305, 32'h1001);
        csr(RD, 12'h305, 32'h0);
        n_checks++; if (csr_data_out !== 32'h1001) begin n_fail++; $display("FAIL mtvec_vec: got %h want %h", csr_data_out, 32'h1001); end
        trap_cause = 32'h8000_000B; trap_pc = 32'h0000_0203; trap_tval = 32'h0000_0BAD;
        #1;
        n_checks++; if (trap_vector !== 32'h102C) begin n_fail++; $display("FAIL tvec_vectored: got %h want %h", trap_vector, 32'h102C); end
        trap_valid = 1'b1;
        @(posedge clk); #1 trap_valid = 1'b0;
        n_checks++; if (epc_out !== 32'h200) begin n_fail++; $display("FAIL trap_mepc: got %h want %h", epc_out, 32'h200); end
        csr(RD, 12'h342, 32'h0);
        n_checks++; if (csr_data_out !== 32'h8000_000B) begin n_fail++; $display("FAIL trap_mcause: got %h want %h", csr_data_out, 32'h8000_000B); end
        csr(RD, 12'h343, 32'h0);
        n_checks++; if (csr_data_out !== 32'h0BAD) begin n_fail++; $display("FAIL trap_mtval: got %h want %h", csr_data_out, 32'h0BAD); end
        csr(RD, 12'h300, 32'h0);
        n_checks++; if (csr_data_out !== 32'h80) begin n_fail++; $display("FAIL trap_mstatus: got %h want %h", csr_data_out, 32'h80); end
        mret = 1'b1;
        @(posedge clk); #1 mret = 1'b0;
        csr(RD, 12'h300, 32'h0);
        n_checks++; if (csr_data_out !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus: got %h want %h", csr_data_out, 32'h88); end
        n_checks++; if (epc_out !== 32'h200) begin n_fail++; $display("FAIL mret_epc: got %h want %h", epc_out, 32'h200); end
        trap_cause = 32'h0000_000B; #1;
        n_checks++; if (trap_vector !== 32'h1000) begin n_fail++; $display("FAIL tvec_exception: got %h want %h", trap_vector, 32'h1000); end
        csr(RW, 12'h305, 32'h1003);
        csr(RD, 12'h305, 32'h0);
        n_checks++; if (csr_data_out !== 32'h1000) begin n_fail++; $display("FAIL mtvec_mode1x: got %h want %h", csr_data_out, 32'h1000); end
        trap_cause = 32'h8000_000B; #1;
        n_checks++; if (trap_vector !== 32'h1000) begin n_fail++; $display("FAIL tvec_direct: got %h want %h", trap_vector, 32'h1000); end
    endtask

    task automatic test_same_cycle;
        trap_cause = 32'h5; trap_pc = 32'h3002; trap_tval = 32'h0; trap_valid = 1'b1;
        csr(RW, 12'h341, 32'h1234);
        trap_valid = 1'b0;
        n_checks++; if (csr_data_out !== 32'h200) begin n_fail++; $display("FAIL sc_mepc_old: got %h want %h", csr_data_out, 32'h200); end
        n_checks++; if (epc_out !== 32'h3000) begin n_fail++; $display("FAIL sc_mepc: got %h want %h", epc_out, 32'h3000); end
        trap_pc = 32'h4000; trap_valid = 1'b1;
        csr(RW, 12'h340, 32'h55);
        trap_valid = 1'b0;
        n_checks++; if (epc_out !== 32'h4000) begin n_fail++; $display("FAIL sc_mepc2: got %h want %h", epc_out, 32'h4000); end
        csr(RD, 12'h340, 32'h0);
        n_checks++; if (csr_data_out !== 32'h55) begin n_fail++; $display("FAIL sc_mscratch: got %h want %h", csr_data_out, 32'h55); end
        mret = 1'b1;
        csr(RW, 12'h300, 32'h8);
        mret = 1'b0;
        n_checks++; if (csr_data_out !== 32'h0) begin n_fail++; $display("FAIL sc_mstatus_old: got %h want %h", csr_data_out, 32'h0); end
        csr(RD, 12'h300, 32'h0);
        n_checks++; if (csr_data_out !== 32'h80) begin n_fail++; $display("FAIL sc_mret_wins: got %h want %h", csr_data_out, 32'h80); end
    endtask

    task automatic test_irq;
        csr(RW, 12'h304, 32'hFFFF_FFFF);
        csr(RD, 12'h304, 32'h0);
        n_checks++; if (csr_data_out !== 32'h888) begin n_fail++; $display("FAIL mie_mask: got %h want %h", csr_data_out, 32'h888); end
        csr(RW, 12'h304, 32'h80);
        csr(RW, 12'h300, 32'h8);
        irq_sw = 1'b1; #1;
        n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq_pending); end
        irq_timer = 1'b1; #1;
        n_checks++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_timer: got %b want 1", irq_pending); end
        csr(RD, 12'h344, 32'h0);
        n_checks++; if (csr_data_out !== 32'h88) begin n_fail++; $display("FAIL mip: got %h want %h", csr_data_out, 32'h88); end
        csr(RW, 12'h300, 32'h0);
        n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_mie_off: got %b want 0", irq_pending); end
    endtask

    task automatic test_async_reset;
        csr(RW, 12'h300, 32'h8);
        csr(RD, 12'h340, 32'h0);
        trap_cause = 32'h0;
        n_checks++; if (csr_data_out !== 32'h55) begin n_fail++; $display("FAIL pre_reset_data: got %h want %h", csr_data_out, 32'h55); end
        n_checks++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", irq_pending); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (csr_data_out !== 32'h0) begin n_fail++; $display("FAIL arst_data: got %h want %h", csr_data_out, 32'h0); end
        n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL arst_irq: got %b want 0", irq_pending); end
        n_checks++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL arst_epc: got %h want %h", epc_out, 32'h0); end
        n_checks++; if (trap_vector !== 32'h0) begin n_fail++; $display("FAIL arst_tvec: got %h want %h", trap_vector, 32'h0); end
        @(posedge clk); #1 rst_n = 1'b1;
        csr(RD, 12'hB00, 32'h0);
        n_checks++; if (csr_data_out !== 32'h0) begin n_fail++; $display("FAIL arst_mcycle0: got %h want %h", csr_data_out, 32'h0); end
        csr(RD, 12'hB00, 32'h0);
        n_checks++; if (csr_data_out !== 32'h1) begin n_fail++; $display("FAIL arst_mcycle1: got %h want %h", csr_data_out, 32'h1); end
        csr(RD, 12'h340, 32'h0);
        n_checks++; if (csr_data_out !== 32'h0) begin n_fail++; $display("FAIL arst_mscratch: got %h want %h", csr_data_out, 32'h0); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset;
        test_rmw;
        test_illegal;
        test_counters;
        test_trap;
        test_same_cycle;
        test_irq;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
